rr_arbiter_pipe: RTL and testbench

- Parametrised round-robin arbiter and multiplexer for N valid/ready streams merging into one downstream stream.
- Adds behaviour the previous arbiter lacks:
  - a registered output slice, so `valid_out` is true only when a granted beat is held;
  - a source-ID sideband on the output;
  - packet-aware grant locking, so multi-beat packets are never interleaved.
- Sits between several producer channels and a single shared consumer.

---
 rtl/rr_arbiter_pipe.sv | 83 ++++++++
 tb/tb_rr_arbiter_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_pipe.sv
// rr_arbiter_pipe: round-robin N-to-1 valid/ready arbiter with a registered output slice and source-ID sideband.
// Define ARB_PKT_LOCK_EN to hold the grant until a last beat so packets never interleave.
module rr_arbiter_pipe #(
    parameter int REQ_WIDTH = 4,
    parameter int DW = 8,
    localparam int ID_W = $clog2(REQ_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REQ_WIDTH-1:0]    valid_in,
    input  logic [REQ_WIDTH*DW-1:0] data_in,
    input  logic [REQ_WIDTH-1:0]    last_in,
    output logic [REQ_WIDTH-1:0]    ready_out,
    input  logic                    ready_in,
    output logic                    valid_out,
    output logic [DW-1:0]           data_out,
    output logic                    last_out,
    output logic [ID_W-1:0]         id_out
);
    logic [ID_W-1:0] ptr, k, rr_k, k_nxt;
    logic found, rr_found, slot_free, acc, grant_end;
    logic [REQ_WIDTH-1:0] grant;

    // first valid channel scanning circularly from ptr
    always_comb begin
        rr_found = 1'b0;
        rr_k = '0;
        for (int j = 0; j < REQ_WIDTH; j++) begin
            if (!rr_found && valid_in[(int'(ptr) + j) % REQ_WIDTH]) begin
                rr_found = 1'b1;
                rr_k = ID_W'((int'(ptr) + j) % REQ_WIDTH);
            end
        end
    end

`ifdef ARB_PKT_LOCK_EN
    localparam logic UNLOCKED = 1'b0;
    localparam logic LOCKED = 1'b1;
    logic state;
    logic [ID_W-1:0] lock_id;
    // a locked grant stays on lock_id even if that channel pauses mid-packet
    assign found = (state == LOCKED) | rr_found;
    assign k = (state == LOCKED) ? lock_id : rr_k;
    assign grant_end = last_in[k];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= UNLOCKED;
            lock_id <= '0;
        end else if (acc) begin
            state <= last_in[k] ? UNLOCKED : LOCKED;
            if (!last_in[k]) lock_id <= k;
        end
    end
`else
    assign found = rr_found;
    assign k = rr_k;
    assign grant_end = 1'b1;
`endif

    assign grant = found ? (REQ_WIDTH'(1) << k) : '0;
    assign slot_free = ~valid_out | ready_in;
    assign ready_out = grant & {REQ_WIDTH{slot_free}};
    assign acc = |(valid_in & ready_out);
    assign k_nxt = (k == ID_W'(REQ_WIDTH - 1)) ? '0 : k + ID_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out <= '0;
            last_out <= 1'b0;
            id_out <= '0;
            ptr <= '0;
        end else if (acc) begin
            valid_out <= 1'b1;
            data_out <= data_in[k*DW +: DW];
            last_out <= last_in[k];
            id_out <= k;
            if (grant_end) ptr <= k_nxt;
        end else if (ready_in) begin
            valid_out <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_arbiter_pipe.sv
// tb_rr_arbiter_pipe: directed and randomized checks of rr_arbiter_pipe against a behavioural model.
module tb_rr_arbiter_pipe;
    localparam int N = 4;
    localparam int DW = 8;

    logic clk, rst;
    logic [N-1:0] valid_in, last_in, ready_out;
    logic [N*DW-1:0] data_in;
    logic ready_in, valid_out, last_out;
    logic [DW-1:0] data_out;
    logic [1:0] id_out;

    logic [2:0] v3, l3, ro3;
    logic [3*DW-1:0] d3;
    logic r3, vo3, lo3;
    logic [DW-1:0] do3;
    logic [1:0] id3;

    int vectors = 0;
    int miscompares = 0;

    int mptr, mlock_id, mid;
    bit mlocked;
    logic mv, ml;
    logic [DW-1:0] md;

    rr_arbiter_pipe #(.REQ_WIDTH(N), .DW(DW)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .last_in(last_in),
        .ready_out(ready_out), .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out),
        .last_out(last_out), .id_out(id_out)
    );

    rr_arbiter_pipe #(.REQ_WIDTH(3), .DW(DW)) dut3 (
        .clk(clk), .rst(rst), .valid_in(v3), .data_in(d3), .last_in(l3),
        .ready_out(ro3), .ready_in(r3), .valid_out(vo3), .data_out(do3),
        .last_out(lo3), .id_out(id3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mreset();
        mptr = 0; mlock_id = 0; mlocked = 0;
        mv = 0; ml = 0; md = '0; mid = 0;
    endtask

    // one clock of stimulus: compare ready, advance the model across the edge, compare the slice
    task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic [N-1:0] l,
                        input logic r, output int a);
        int g;
        logic slot;
        logic [N-1:0] er;
        valid_in = v; data_in = d; last_in = l; ready_in = r;
        #1;
        g = -1;
        if (mlocked) g = mlock_id;
        else for (int j = 0; j < N; j++) if (g < 0 && v[(mptr + j) % N]) g = (mptr + j) % N;
        slot = !mv || r;
        er = (g >= 0 && slot) ? (N'(1) << g) : '0;
        check("ready_out", ready_out, er);
        a = (g >= 0 && slot && v[g]) ? g : -1;
        @(posedge clk);
        if (a >= 0) begin
            mv = 1; md = d[a*DW +: DW]; ml = l[a]; mid = a;
`ifdef ARB_PKT_LOCK_EN
            if (!mlocked && !l[a]) begin
                mlocked = 1; mlock_id = a;
            end else if (mlocked && l[a]) mlocked = 0;
            if (l[a]) mptr = (a + 1) % N;
`else
            mptr = (a + 1) % N;
`endif
        end else if (r) mv = 0;
        @(negedge clk);
        check("valid_out", valid_out, mv);
        check("data_out", data_out, md);
        check("last_out", last_out, ml);
        check("id_out", id_out, mid);
    endtask

    initial begin
        int a, b;
        int lock_exp[4];
        logic [N*DW-1:0] d;
        logic [N-1:0] pv, pl, v, l;
        logic [DW-1:0] pd [N];

        rst = 1; valid_in = '0; data_in = '0; last_in = '0; ready_in = 0;
        v3 = '0; d3 = '0; l3 = '0; r3 = 0;
        mreset();
        repeat (2) @(negedge clk);
        check("init_valid", valid_out, 0);
        check("init_id", id_out, 0);
        check("init_ready", ready_out, 0);
        rst = 0;

        step(4'b0100, 32'h00A50000, 4'b0100, 1, a);
        valid_in = '0;
        rst = 1;
        #1;
        check("rst_valid", valid_out, 0);
        check("rst_id", id_out, 0);
        check("rst_ready", ready_out, 0);
        mreset();
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 8; i++) begin
            step(4'hF, 32'h13121110, 4'hF, 1, a);
            check("fair_id", id_out, i % 4);
            check("fair_data", data_out, 8'h10 + i % 4);
        end

        step(4'b0100, 32'h00A50000, 4'b0100, 1, a);
        for (int i = 0; i < 5; i++) begin
            step(4'b0001, 32'h0000003C, 4'b0001, 0, a);
            check("bp_data", data_out, 8'hA5);
            check("bp_id", id_out, 2);
            check("bp_ready", ready_out, 0);
        end
        step(4'b0001, 32'h0000003C, 4'b0001, 1, a);
        check("bp_next_id", id_out, 0);
        check("bp_next_data", data_out, 8'h3C);

`ifdef ARB_PKT_LOCK_EN
        lock_exp = '{1, 1, 1, 0};
`else
        lock_exp = '{1, 0, 1, 0};
`endif
        b = 0;
        for (int c = 0; c < 4; c++) begin
            v = 4'b0001 | ((b < 3) ? 4'b0010 : 4'b0000);
            l = 4'b0001 | ((b == 2) ? 4'b0010 : 4'b0000);
            d = '0;
            d[DW +: DW] = 8'h50 + 8'(b);
            d[0 +: DW] = 8'h60 + 8'(c);
            step(v, d, l, 1, a);
            if (a == 1) b++;
            check("lock_seq", id_out, lock_exp[c]);
        end

        step(4'b1000, 32'h77000000, 4'b0000, 1, a);
        valid_in = '0;
        rst = 1;
        #1;
        check("mid_rst_valid", valid_out, 0);
        mreset();
        @(negedge clk);
        rst = 0;
        step(4'hF, 32'h13121110, 4'hF, 1, a);
        check("post_rst_id", id_out, 0);

        pv = '0; pl = '0;
        for (int i = 0; i < N; i++) pd[i] = '0;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    pv[i] = 1;
                    pd[i] = 8'($urandom);
                    pl[i] = ($urandom_range(0, 2) == 0);
                end
            end
            d = '0;
            for (int i = 0; i < N; i++) d[i*DW +: DW] = pd[i];
            step(pv, d, pl, $urandom_range(0, 3) != 0, a);
            if (a >= 0) pv[a] = 0;
        end

        v3 = 3'b101; d3 = 24'hC2C1C0; l3 = 3'b111; r3 = 1;
        #1;
        check("w3_ready", ro3, 3'b001);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("w3_valid", vo3, 1);
            check("w3_id", id3, (i % 2) ? 2 : 0);
            check("w3_data", do3, (i % 2) ? 8'hC2 : 8'hC0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
